// File: rtl/bridge_pkg.sv
// Shared bridge constants: FSM state encodings and halfword/lane helpers.
package bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    COMPL  = 2'b10
  } state_e;

  function automatic logic [15:0] sel_half(input logic [31:0] word, input logic hi);
    return hi ? word[31:16] : word[15:0];
  endfunction

  function automatic logic [3:0] lane_be(input logic hi, input logic [1:0] be);
    return hi ? {be, 2'b00} : {2'b00, be};
  endfunction

endpackage

// File: rtl/bridge_rd_buf.sv
// One-word read buffer: lookup, fill on target read, byte-merge on matching write.
// Latency: combinational lookup, one-cycle update; backpressure: none, updates are single-cycle strobes.
module bridge_rd_buf #(
  parameter bit EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] lookup_tag,
  output logic        hit,
  output logic [31:0] buf_dat,
  input  logic [29:0] upd_tag,
  input  logic        fill_vld,
  input  logic [31:0] fill_dat,
  input  logic        wr_vld,
  input  logic [31:0] wr_dat,
  input  logic [3:0]  wr_be
);

  logic        valid;
  logic [29:0] tag;
  logic [31:0] data;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (fill_vld) begin
      valid <= EN;
      tag   <= upd_tag;
      data  <= fill_dat;
    end else if (wr_vld && valid && (tag == upd_tag)) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) data[8*i +: 8] <= wr_dat[8*i +: 8];
      end
    end
  end

  assign hit     = EN && valid && (tag == lookup_tag);
  assign buf_dat = data;

endmodule

// File: rtl/bridge_16_32.sv
// 16-bit host to 32-bit target bridge with optional one-word read buffer.
// Latency: hit 1 cycle after accept, miss/write 1 cycle after b_compl; backpressure: host holds request until h_compl.
module bridge_16_32
  import bridge_pkg::*;
#(
  parameter int RD_BUF_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        h_cs,
  input  logic [31:0] h_addr,
  input  logic [15:0] h_wdata,
  output logic [15:0] h_rdata,
  input  logic        h_wr_en,
  input  logic [1:0]  h_bytesel,
  output logic        h_compl,
  output logic [31:0] b_addr,
  output logic [31:0] b_wdata,
  input  logic [31:0] b_rdata,
  output logic        b_wr_en,
  output logic [3:0]  b_bytesel,
  input  logic        b_compl
);

  state_e      state, state_nxt;
  logic        accept, buf_hit, rd_hit, t_done;
  logic [31:0] buf_dat;
  logic        unused_addr0;

  assign unused_addr0 = h_addr[0];
  assign accept = (state == IDLE) && h_cs && (h_bytesel != 2'b00);
  assign rd_hit = buf_hit && !h_wr_en;
  // b_compl only means something while a target transfer is outstanding.
  assign t_done = (state == ACCESS) && b_compl;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = rd_hit ? COMPL : ACCESS;
      ACCESS:  if (b_compl) state_nxt = COMPL;
      COMPL:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    h_compl = (state == COMPL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_addr    <= '0;
      b_wdata   <= '0;
      b_wr_en   <= 1'b0;
      b_bytesel <= 4'b0000;
    end else if (accept && !rd_hit) begin
      b_addr    <= {h_addr[31:2], 2'b00};
      b_wdata   <= {h_wdata, h_wdata};
      b_wr_en   <= h_wr_en;
      b_bytesel <= lane_be(h_addr[1], h_bytesel);
    end else if (t_done) begin
      b_bytesel <= 4'b0000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                    h_rdata <= '0;
    else if (accept && rd_hit)  h_rdata <= sel_half(buf_dat, h_addr[1]);
    else if (t_done && !b_wr_en) h_rdata <= sel_half(b_rdata, h_addr[1]);
  end

  bridge_rd_buf #(.EN(RD_BUF_EN != 0)) u_rd_buf (
    .clk        (clk),
    .rst        (rst),
    .lookup_tag (h_addr[31:2]),
    .hit        (buf_hit),
    .buf_dat    (buf_dat),
    .upd_tag    (b_addr[31:2]),
    .fill_vld   (t_done && !b_wr_en),
    .fill_dat   (b_rdata),
    .wr_vld     (t_done && b_wr_en),
    .wr_dat     (b_wdata),
    .wr_be      (b_bytesel)
  );

endmodule

// File: tb/tb_bridge_16_32.sv
// Directed bench for bridge_16_32 with buffer enabled and a second instance with it disabled.
module tb_bridge_16_32;

  logic        clk = 1'b0;
  logic        rst = 1'b0, nb_rst = 1'b0;
  logic        h_cs = 1'b0, h_wr_en = 1'b0;
  logic [31:0] h_addr = '0;
  logic [15:0] h_wdata = '0;
  logic [1:0]  h_bytesel = 2'b00;
  logic [31:0] b_rdata = '0;
  logic        b_compl = 1'b0, nb_b_compl = 1'b0;

  logic [15:0] h_rdata, nb_h_rdata;
  logic        h_compl, nb_h_compl;
  logic [31:0] b_addr, b_wdata, nb_b_addr, nb_b_wdata;
  logic        b_wr_en, nb_b_wr_en;
  logic [3:0]  b_bytesel, nb_b_bytesel;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  bridge_16_32 #(.RD_BUF_EN(1)) dut (
    .clk(clk), .rst(rst), .h_cs(h_cs), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_rdata(h_rdata), .h_wr_en(h_wr_en), .h_bytesel(h_bytesel), .h_compl(h_compl),
    .b_addr(b_addr), .b_wdata(b_wdata), .b_rdata(b_rdata), .b_wr_en(b_wr_en),
    .b_bytesel(b_bytesel), .b_compl(b_compl)
  );

  bridge_16_32 #(.RD_BUF_EN(0)) dut_nb (
    .clk(clk), .rst(nb_rst), .h_cs(h_cs), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_rdata(nb_h_rdata), .h_wr_en(h_wr_en), .h_bytesel(h_bytesel), .h_compl(nb_h_compl),
    .b_addr(nb_b_addr), .b_wdata(nb_b_wdata), .b_rdata(b_rdata), .b_wr_en(nb_b_wr_en),
    .b_bytesel(nb_b_bytesel), .b_compl(nb_b_compl)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_req(input logic [31:0] addr, input logic wr,
                          input logic [15:0] wdat, input logic [1:0] be);
    h_cs = 1'b1; h_addr = addr; h_wr_en = wr; h_wdata = wdat; h_bytesel = be;
  endtask

  task automatic host_drop();
    h_cs = 1'b0; h_bytesel = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b1; nb_rst = 1'b1;
    tick(); tick();
    rst = 1'b0; nb_rst = 1'b0;
    checks++; if (h_compl !== 1'b0) $display("FAIL rst_h_compl: got %b want 0", h_compl); else passed++;
    checks++; if (h_rdata !== 16'h0) $display("FAIL rst_h_rdata: got %h want 0000", h_rdata); else passed++;
    checks++; if (b_addr !== 32'h0) $display("FAIL rst_b_addr: got %h want 0", b_addr); else passed++;
    checks++; if (b_wdata !== 32'h0) $display("FAIL rst_b_wdata: got %h want 0", b_wdata); else passed++;
    checks++; if (b_wr_en !== 1'b0) $display("FAIL rst_b_wr_en: got %b want 0", b_wr_en); else passed++;
    checks++; if (b_bytesel !== 4'b0000) $display("FAIL rst_b_bytesel: got %b want 0000", b_bytesel); else passed++;
  endtask

  task automatic test_read_miss();
    host_req(32'h1002, 1'b0, 16'h0, 2'b11);
    tick();
    checks++; if (b_addr !== 32'h1000) $display("FAIL miss_b_addr: got %h want 00001000", b_addr); else passed++;
    checks++; if (b_bytesel !== 4'b1100) $display("FAIL miss_b_bytesel: got %b want 1100", b_bytesel); else passed++;
    checks++; if (b_wr_en !== 1'b0) $display("FAIL miss_b_wr_en: got %b want 0", b_wr_en); else passed++;
    tick(); tick();
    checks++; if (h_compl !== 1'b0) $display("FAIL miss_early_compl: got %b want 0", h_compl); else passed++;
    b_rdata = 32'hAABBCCDD; b_compl = 1'b1;
    tick();
    b_compl = 1'b0;
    checks++; if (h_compl !== 1'b1) $display("FAIL miss_h_compl: got %b want 1", h_compl); else passed++;
    checks++; if (h_rdata !== 16'hAABB) $display("FAIL miss_h_rdata: got %h want aabb", h_rdata); else passed++;
    checks++; if (b_bytesel !== 4'b0000) $display("FAIL miss_bytesel_clr: got %b want 0000", b_bytesel); else passed++;
    host_drop();
    tick();
    checks++; if (h_compl !== 1'b0) $display("FAIL miss_single_pulse: got %b want 0", h_compl); else passed++;
  endtask

  task automatic test_buffer_hit();
    host_req(32'h1000, 1'b0, 16'h0, 2'b11);
    tick();
    checks++; if (h_compl !== 1'b1) $display("FAIL hit_h_compl: got %b want 1", h_compl); else passed++;
    checks++; if (h_rdata !== 16'hCCDD) $display("FAIL hit_h_rdata: got %h want ccdd", h_rdata); else passed++;
    checks++; if (b_bytesel !== 4'b0000) $display("FAIL hit_no_target: got %b want 0000", b_bytesel); else passed++;
    host_drop();
    tick();
    checks++; if (h_compl !== 1'b0) $display("FAIL hit_single_pulse: got %b want 0", h_compl); else passed++;
  endtask

  task automatic test_write_merge();
    host_req(32'h1001, 1'b1, 16'h1234, 2'b10);
    tick();
    checks++; if (b_wdata !== 32'h12341234) $display("FAIL wr_b_wdata: got %h want 12341234", b_wdata); else passed++;
    checks++; if (b_bytesel !== 4'b0010) $display("FAIL wr_b_bytesel: got %b want 0010", b_bytesel); else passed++;
    checks++; if (b_wr_en !== 1'b1) $display("FAIL wr_b_wr_en: got %b want 1", b_wr_en); else passed++;
    checks++; if (b_addr !== 32'h1000) $display("FAIL wr_b_addr: got %h want 00001000", b_addr); else passed++;
    tick();
    b_compl = 1'b1;
    tick();
    b_compl = 1'b0;
    checks++; if (h_compl !== 1'b1) $display("FAIL wr_h_compl: got %b want 1", h_compl); else passed++;
    checks++; if (h_rdata !== 16'hCCDD) $display("FAIL wr_rdata_kept: got %h want ccdd", h_rdata); else passed++;
    host_drop();
    tick();
    host_req(32'h1000, 1'b0, 16'h0, 2'b11);
    tick();
    checks++; if (h_compl !== 1'b1) $display("FAIL merge_h_compl: got %b want 1", h_compl); else passed++;
    checks++; if (h_rdata !== 16'h12DD) $display("FAIL merge_h_rdata: got %h want 12dd", h_rdata); else passed++;
    checks++; if (b_bytesel !== 4'b0000) $display("FAIL merge_no_target: got %b want 0000", b_bytesel); else passed++;
    host_drop();
    tick();
  endtask

  task automatic test_back_to_back();
    host_req(32'h1002, 1'b0, 16'h0, 2'b11);
    tick();
    checks++; if (h_rdata !== 16'hAABB) $display("FAIL b2b_first_rdata: got %h want aabb", h_rdata); else passed++;
    h_addr = 32'h1000;
    tick();
    checks++; if (h_compl !== 1'b0) $display("FAIL b2b_gap: got %b want 0", h_compl); else passed++;
    tick();
    checks++; if (h_compl !== 1'b1) $display("FAIL b2b_second_compl: got %b want 1", h_compl); else passed++;
    checks++; if (h_rdata !== 16'h12DD) $display("FAIL b2b_second_rdata: got %h want 12dd", h_rdata); else passed++;
    host_drop();
    tick();
  endtask

  task automatic test_abandon();
    host_req(32'h3000, 1'b0, 16'h0, 2'b11);
    tick();
    checks++; if (b_bytesel !== 4'b0011) $display("FAIL ab_access: got %b want 0011", b_bytesel); else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    host_drop();
    checks++; if (b_bytesel !== 4'b0000) $display("FAIL ab_rst_bytesel: got %b want 0000", b_bytesel); else passed++;
    b_rdata = 32'hDEADBEEF; b_compl = 1'b1;
    tick();
    b_compl = 1'b0;
    checks++; if (h_compl !== 1'b0) $display("FAIL ab_stray_compl: got %b want 0", h_compl); else passed++;
    tick();
    checks++; if (h_compl !== 1'b0) $display("FAIL ab_stray_late: got %b want 0", h_compl); else passed++;
    checks++; if (b_bytesel !== 4'b0000) $display("FAIL ab_stray_bytesel: got %b want 0000", b_bytesel); else passed++;
    host_req(32'h1000, 1'b0, 16'h0, 2'b11);
    tick();
    checks++; if (b_bytesel !== 4'b0011) $display("FAIL ab_post_miss: got %b want 0011", b_bytesel); else passed++;
    checks++; if (h_compl !== 1'b0) $display("FAIL ab_post_no_hit: got %b want 0", h_compl); else passed++;
    b_rdata = 32'h55667788; b_compl = 1'b1;
    tick();
    b_compl = 1'b0;
    checks++; if (h_rdata !== 16'h7788) $display("FAIL ab_post_rdata: got %h want 7788", h_rdata); else passed++;
    host_drop();
    tick();
  endtask

  task automatic test_idle_filter();
    host_req(32'h4000, 1'b0, 16'h0, 2'b00);
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (b_bytesel !== 4'b0000) $display("FAIL idle_bytesel cycle %0d: got %b want 0000", i, b_bytesel); else passed++;
      checks++; if (h_compl !== 1'b0) $display("FAIL idle_compl cycle %0d: got %b want 0", i, h_compl); else passed++;
    end
    host_drop();
    tick();
  endtask

  task automatic test_buf_disabled();
    logic [31:0] rdat [2];
    logic [15:0] want [2];
    rdat[0] = 32'h0BAD1111; want[0] = 16'h1111;
    rdat[1] = 32'h0BAD2222; want[1] = 16'h2222;
    nb_rst = 1'b1;
    tick();
    nb_rst = 1'b0;
    for (int n = 0; n < 2; n++) begin
      host_req(32'h2000, 1'b0, 16'h0, 2'b11);
      tick();
      checks++; if (nb_b_bytesel !== 4'b0011) $display("FAIL nobuf_target_read %0d: got %b want 0011", n, nb_b_bytesel); else passed++;
      checks++; if (nb_h_compl !== 1'b0) $display("FAIL nobuf_no_hit %0d: got %b want 0", n, nb_h_compl); else passed++;
      b_rdata = rdat[n]; nb_b_compl = 1'b1;
      tick();
      nb_b_compl = 1'b0;
      checks++; if (nb_h_rdata !== want[n]) $display("FAIL nobuf_rdata %0d: got %h want %h", n, nb_h_rdata, want[n]); else passed++;
      checks++; if (nb_h_compl !== 1'b1) $display("FAIL nobuf_compl %0d: got %b want 1", n, nb_h_compl); else passed++;
      host_drop();
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_buffer_hit();
    test_write_merge();
    test_back_to_back();
    test_abandon();
    test_idle_filter();
    test_buf_disabled();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
